serial_subtractor_nb: RTL and testbench

- Multi-cycle N-bit subtractor: computes oDiff = iA - iB - iBorrowIn one CHUNK-bit slice per clock, LSB slice first.
- Borrow ripples between slices through a registered borrow bit.
- It is the inverse-operation companion to the arithmetic accelerator's combinational carry-select adder, using the same operand width and operand/result naming.
- It sits behind a valid/ready handshake on both input and output, so it can be chained with other accelerator stages.

---
 rtl/serial_subtractor_nb.sv | 117 +++++++++++
 tb/tb_serial_subtractor_nb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_nb.sv
// Multi-cycle unsigned subtractor: A - B - borrow_in, one CHUNK-bit slice per clock, LSB first.
// Valid/ready on both sides. A transfer happens on a rising edge where valid and ready are both high.
// The producer holds its data stable while valid is high and ready is low.
module serial_subtractor_nb #(
  parameter int N     = 128,
  parameter int CHUNK = 32
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iValid,
  output logic         oReady,
  input  logic [N-1:0] iA,
  input  logic [N-1:0] iB,
  input  logic         iBorrowIn,
  output logic         oValid,
  input  logic         iReady,
  output logic [N-1:0] oDiff,
  output logic         oBorrow,
  output logic [1:0]   oDbgState
);

  localparam int SLICES = N / CHUNK;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       r_acc;
  logic [N-1:0]       r_diff;
  logic               r_bw;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic [CHUNK:0]     w_sum;
  logic [N-1:0]       w_acc_next;
  logic               w_last;
  logic               w_accept;

  // Subtraction as A + ~B + ~borrow; the carry out of the slice is the inverted borrow out.
  assign w_sum  = {1'b0, r_a[CHUNK-1:0]} + {1'b0, ~r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, ~r_bw};
  assign w_last = (r_cnt == CNT_W'(SLICES - 1));

  generate
    if (SLICES == 1) begin : g_single
      assign w_acc_next = w_sum[CHUNK-1:0];
    end else begin : g_multi
      assign w_acc_next = {w_sum[CHUNK-1:0], r_acc[N-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    oReady       = 1'b0;
    oValid       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        oReady   = 1'b1;
        w_accept = iValid;
        if (iValid) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        oValid = 1'b1;
        if (iReady) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Operands shift right so the current slice always sits in the low CHUNK bits.
  // The result is published only when complete, so oDiff never shows partial slices.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_bw     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a   <= iA;
      r_b   <= iB;
      r_bw  <= iBorrowIn;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> CHUNK;
      r_b   <= r_b >> CHUNK;
      r_acc <= w_acc_next;
      r_bw  <= ~w_sum[CHUNK];
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff   <= w_acc_next;
        r_borrow <= ~w_sum[CHUNK];
      end
    end
  end

  assign oDiff     = r_diff;
  assign oBorrow   = r_borrow;
  assign oDbgState = r_state;

endmodule

// File: tb/tb_serial_subtractor_nb.sv
// Directed bench for serial_subtractor_nb with hand-computed expected differences.
module tb_serial_subtractor_nb;

  localparam int N = 128;
  localparam int CHUNK = 32;

  logic         iClk;
  logic         iRst;
  logic         iValid;
  logic         oReady;
  logic [N-1:0] iA;
  logic [N-1:0] iB;
  logic         iBorrowIn;
  logic         oValid;
  logic         iReady;
  logic [N-1:0] oDiff;
  logic         oBorrow;
  logic [1:0]   oDbgState;

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor_nb #(.N(N), .CHUNK(CHUNK)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iValid    (iValid),
    .oReady    (oReady),
    .iA        (iA),
    .iB        (iB),
    .iBorrowIn (iBorrowIn),
    .oValid    (oValid),
    .iReady    (iReady),
    .oDiff     (oDiff),
    .oBorrow   (oBorrow),
    .oDbgState (oDbgState)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Drives one operation; hold>0 keeps iReady low for that many cycles in DONE.
  task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic bin, input logic [N-1:0] exp_diff, input logic exp_bo,
                       input int hold);
    int lat;
    logic [N-1:0] held_diff;
    logic         held_bo;
    @(negedge iClk);
    iA = a; iB = b; iBorrowIn = bin; iValid = 1'b1;
    iReady = (hold == 0);
    check({tag, "_ready"}, N'(oReady), N'(1));
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iA = ~a; iB = a;  // operand change during RUN must not matter
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge iClk);
      #1;
      lat++;
      if (oValid) break;
    end
    check({tag, "_latency"}, N'(lat), N'(4));
    check({tag, "_diff"}, oDiff, exp_diff);
    check({tag, "_borrow"}, N'(oBorrow), N'(exp_bo));
    if (hold > 0) begin
      held_diff = oDiff;
      held_bo   = oBorrow;
      for (int i = 0; i < hold; i++) begin
        @(negedge iClk);
        iValid = (i % 2 == 0);
        @(posedge iClk);
        #1;
        if (oValid !== 1'b1 || oReady !== 1'b0 || oDiff !== held_diff || oBorrow !== held_bo)
          check({tag, "_hold"}, {oValid, oReady, oBorrow}, {3'b101, held_bo});
      end
      check({tag, "_hold_diff"}, oDiff, exp_diff);
      check({tag, "_hold_valid"}, N'(oValid), N'(1));
      @(negedge iClk);
      iValid = 1'b0;
      iReady = 1'b1;
    end
    @(posedge iClk);
    #1;
    check({tag, "_valid_low"}, N'(oValid), N'(0));
    check({tag, "_ready_high"}, N'(oReady), N'(1));
  endtask

  initial begin
    logic [N-1:0] all_ones;
    all_ones = '1;
    iRst = 1'b1; iValid = 1'b0; iA = '0; iB = '0; iBorrowIn = 1'b0; iReady = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_valid", N'(oValid), N'(0));
    check("rst_ready", N'(oReady), N'(1));
    check("rst_diff", oDiff, '0);
    check("rst_borrow", N'(oBorrow), N'(0));
    check("rst_state", N'(oDbgState), N'(0));
    @(negedge iClk);
    iRst = 1'b0;

    do_op("basic", 128'd2245456, 128'd25643, 1'b1, 128'd2219812, 1'b0, 0);
    do_op("wrap", 128'd0, 128'd0, 1'b1, all_ones, 1'b1, 0);
    do_op("mid", 128'd22564654562, 128'd12346523, 1'b0, 128'd22552308039, 1'b0, 0);
    do_op("x32", 128'h1_0000_0000, 128'd1, 1'b0, 128'hFFFF_FFFF, 1'b0, 0);
    do_op("x96", {32'd1, 96'd0}, 128'd1, 1'b0, {32'd0, {96{1'b1}}}, 1'b0, 0);
    do_op("under", 128'd13553152, 128'd46231322, 1'b0, 128'd0 - 128'd32678170, 1'b1, 0);
    do_op("eq", 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
          128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b0, 128'd0, 1'b0, 0);
    do_op("bp", 128'd1000, 128'd1, 1'b1, 128'd998, 1'b0, 10);

    // reset during RUN at slice 2
    @(negedge iClk);
    iA = 128'd500; iB = 128'd1; iBorrowIn = 1'b0; iValid = 1'b1;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    check("mrst_valid", N'(oValid), N'(0));
    check("mrst_ready", N'(oReady), N'(1));
    check("mrst_diff", oDiff, '0);
    check("mrst_borrow", N'(oBorrow), N'(0));
    @(negedge iClk);
    iRst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge iClk);
        #1;
        if (oValid) seen++;
      end
      check("mrst_no_stale", N'(seen), N'(0));
    end
    do_op("after_rst", 128'd2131565, 128'd1534843, 1'b1, 128'd596721, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
